// File: rtl/ifetch_mem_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
package ifetch_mem_pkg;
  localparam int WCNT_W     = 4;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    HOLD
  } state_t;
endpackage

// File: rtl/ifetch_wait_counter.sv
// Loadable down-counter that paces SRAM wait states.
module ifetch_wait_counter
  import ifetch_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              dec,
  output logic [WCNT_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ifetch_mem_responder.sv
// Fetch-side responder: one SRAM byte read per request, with flush.
module ifetch_mem_responder
  import ifetch_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [7:0]        resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  input  logic              resp_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [WCNT_W-1:0] wcnt;
  logic              wzero;
  logic              accept;
  logic              capture;

  assign req_ready = reset_n & ((state == IDLE)
                   | ((state == HOLD) & resp_ready)
                   | flush);
  assign accept    = req_valid & req_ready;
  assign capture   = (state == WAIT) & wzero & ~flush;

  ifetch_wait_counter u_wcnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == ACCESS),
    .load_val (WCNT_W'(WAIT_STATES)),
    .dec      (state == WAIT),
    .count    (wcnt),
    .zero     (wzero)
  );

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // Redirect wins over any pending read or response.
      state_nxt = accept ? ACCESS : IDLE;
    end else begin
      unique case (state)
        IDLE:   if (accept) state_nxt = ACCESS;
        ACCESS: state_nxt = WAIT;
        WAIT:   if (wzero) state_nxt = HOLD;
        HOLD: begin
          if (resp_ready) state_nxt = accept ? ACCESS : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q    <= '0;
      resp_data <= '0;
      resp_addr <= '0;
    end else begin
      if (accept) addr_q <= req_addr;
      if (capture) begin
        resp_data <= mem_rdata;
        resp_addr <= addr_q;
      end
    end
  end

  assign mem_rd     = (state == ACCESS);
  assign mem_addr   = addr_q;
  assign resp_valid = (state == HOLD);

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed bench for ifetch_mem_responder with a delay-line SRAM model.
module tb_ifetch_mem_responder;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // WAIT_STATES=2 instance
  logic        req_valid2, req_ready2, resp_valid2, resp_ready2;
  logic        flush2, mem_rd2;
  logic [15:0] req_addr2, resp_addr2, mem_addr2;
  logic [7:0]  resp_data2, mem_rdata2;
  // WAIT_STATES=0 instance
  logic        req_valid0, req_ready0, resp_valid0, resp_ready0;
  logic        flush0, mem_rd0;
  logic [15:0] req_addr0, resp_addr0, mem_addr0;
  logic [7:0]  resp_data0, mem_rdata0;

  ifetch_mem_responder #(.ADDR_W(16), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_addr(req_addr2), .req_ready(req_ready2),
    .resp_valid(resp_valid2), .resp_data(resp_data2),
    .resp_addr(resp_addr2), .resp_ready(resp_ready2), .flush(flush2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2)
  );

  ifetch_mem_responder #(.ADDR_W(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
    .resp_valid(resp_valid0), .resp_data(resp_data0),
    .resp_addr(resp_addr0), .resp_ready(resp_ready0), .flush(flush0),
    .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_rdata(mem_rdata0)
  );

  function automatic logic [7:0] sram(input logic [15:0] a);
    case (a)
      16'h0040: sram = 8'hA5;
      16'h0041: sram = 8'h3C;
      16'h0100: sram = 8'h11;
      16'h0200: sram = 8'h77;
      16'hFFFF: sram = 8'hC3;
      default:  sram = 8'h00;
    endcase
  endfunction

  // SRAM data appears WAIT_STATES+1 cycles after the mem_rd cycle.
  logic [16:0] p2 [0:2];
  logic [16:0] p0;
  always @(posedge clk) begin
    if (!reset_n) begin
      p2[0] <= '0; p2[1] <= '0; p2[2] <= '0; p0 <= '0;
    end else begin
      p2[0] <= {mem_rd2, mem_addr2};
      p2[1] <= p2[0];
      p2[2] <= p2[1];
      p0    <= {mem_rd0, mem_addr0};
    end
  end
  assign mem_rdata2 = p2[2][16] ? sram(p2[2][15:0]) : 8'hEE;
  assign mem_rdata0 = p0[16] ? sram(p0[15:0]) : 8'hEE;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid2 = 1'b1; req_addr2 = 16'h1234;
    resp_ready2 = 1'b0; flush2 = 1'b0;
    req_valid0 = 1'b0; req_addr0 = 16'h0;
    resp_ready0 = 1'b0; flush0 = 1'b0;
    step(); step();
    checks++;
    if (req_ready2 !== 1'b0) begin
      errors++; $display("FAIL rst_req_ready got %b want 0", req_ready2);
    end
    checks++;
    if (resp_valid2 !== 1'b0) begin
      errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid2);
    end
    checks++;
    if (mem_rd2 !== 1'b0) begin
      errors++; $display("FAIL rst_mem_rd got %b want 0", mem_rd2);
    end
    checks++;
    if ({mem_addr2, resp_addr2, resp_data2} !== 40'h0) begin
      errors++;
      $display("FAIL rst_regs got %h/%h/%h want 0",
               mem_addr2, resp_addr2, resp_data2);
    end
    req_valid2 = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready2 !== 1'b1) begin
      errors++; $display("FAIL rel_req_ready got %b want 1", req_ready2);
    end
  endtask

  // Runs cycles 1..5 after an acceptance and checks timing and payload.
  task automatic run_fetch(input string nm, input logic [15:0] a,
                           input logic [7:0] d);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        req_valid2 = 1'b0; flush2 = 1'b0; resp_ready2 = 1'b0;
      end
      checks++;
      if (mem_rd2 !== (c == 1)) begin
        errors++;
        $display("FAIL %s_mem_rd c%0d got %b want %b", nm, c, mem_rd2, c == 1);
      end
      checks++;
      if (resp_valid2 !== (c == 5)) begin
        errors++;
        $display("FAIL %s_resp_valid c%0d got %b want %b",
                 nm, c, resp_valid2, c == 5);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr2 !== a) begin
          errors++;
          $display("FAIL %s_mem_addr got %h want %h", nm, mem_addr2, a);
        end
      end
      if (c == 5) begin
        checks++;
        if (resp_data2 !== d || resp_addr2 !== a) begin
          errors++;
          $display("FAIL %s_resp got %h@%h want %h@%h",
                   nm, resp_data2, resp_addr2, d, a);
        end
      end
    end
  endtask

  task automatic test_single();
    req_valid2 = 1'b1; req_addr2 = 16'h0040; resp_ready2 = 1'b0;
    #1;
    checks++;
    if (req_ready2 !== 1'b1) begin
      errors++; $display("FAIL single_accept got %b want 1", req_ready2);
    end
    run_fetch("single", 16'h0040, 8'hA5);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid2 !== 1'b1 || resp_data2 !== 8'hA5 ||
          resp_addr2 !== 16'h0040 || req_ready2 !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v%b %h@%h rdy%b want v1 a5@0040 rdy0",
                 i, resp_valid2, resp_data2, resp_addr2, req_ready2);
      end
      step();
    end
    resp_ready2 = 1'b1; req_valid2 = 1'b1; req_addr2 = 16'h0041;
    #1;
    checks++;
    if (req_ready2 !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got %b want 1", req_ready2);
    end
    run_fetch("b2b", 16'h0041, 8'h3C);
    resp_ready2 = 1'b1;
    step();
    resp_ready2 = 1'b0;
    checks++;
    if (resp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain got v%b rdy%b want v0 rdy1",
               resp_valid2, req_ready2);
    end
  endtask

  task automatic test_flush_wait();
    req_valid2 = 1'b1; req_addr2 = 16'h0100;
    step();
    req_valid2 = 1'b0;
    checks++;
    if (mem_rd2 !== 1'b1 || mem_addr2 !== 16'h0100) begin
      errors++;
      $display("FAIL fw_first_rd got %b@%h want 1@0100", mem_rd2, mem_addr2);
    end
    step();
    flush2 = 1'b1; req_valid2 = 1'b1; req_addr2 = 16'h0200;
    #1;
    checks++;
    if (req_ready2 !== 1'b1) begin
      errors++; $display("FAIL fw_accept got %b want 1", req_ready2);
    end
    run_fetch("fw", 16'h0200, 8'h77);
  endtask

  task automatic test_flush_hold();
    resp_ready2 = 1'b1; flush2 = 1'b1; req_valid2 = 1'b0;
    step();
    flush2 = 1'b0; resp_ready2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid2 !== 1'b0 || req_ready2 !== 1'b1 || mem_rd2 !== 1'b0) begin
        errors++;
        $display("FAIL fh_%0d got v%b rdy%b rd%b want v0 rdy1 rd0",
                 i, resp_valid2, req_ready2, mem_rd2);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    resp_ready0 = 1'b1; req_addr0 = 16'hFFFF;
    for (int c = 0; c <= 24; c++) begin
      req_valid0 = (c <= 21);
      #1;
      checks++;
      if (req_ready0 !== (c % 3 == 0) || mem_rd0 !== (c % 3 == 1) ||
          resp_valid0 !== (c % 3 == 0 && c > 0)) begin
        errors++;
        $display("FAIL ws0_c%0d got rdy%b rd%b v%b", c,
                 req_ready0, mem_rd0, resp_valid0);
      end
      if (resp_valid0 === 1'b1) begin
        n++;
        checks++;
        if (resp_data0 !== 8'hC3 || resp_addr0 !== 16'hFFFF) begin
          errors++;
          $display("FAIL ws0_resp c%0d got %h@%h want c3@ffff",
                   c, resp_data0, resp_addr0);
        end
      end
      step();
    end
    req_valid0 = 1'b0;
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL ws0_count got %0d want 8", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush_wait();
    test_flush_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
